// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg
//
// UART transmitter that sends one word per frame. Timing comes from a shared
// oversampling strobe: every bit lasts OVS strobes. Data width is a parameter.
// Parity and stop-bit count are chosen at run time. CTS flow control is
// optional, and the block can also drive a line break.
//
// Frame on the line (LSB first):
//   start(0) | d[0] .. d[DATA_W-1] | [parity] | stop(1) [| stop(1)]
//
// The block sits between a TX FIFO and the pad. The FIFO "not empty" flag
// drives tx_start, and tx_done_tick pops the FIFO.
//
// Parameters
//   DATA_W  data bits per frame (5..9)
//   OVS     oversample strobes per bit (4..64)
//   CTS_EN  1 = a frame may start only while i_cts_n is low; 0 = ignore i_cts_n
//
// Ports
//   clk           system clock
//   rst_n         asynchronous, active-low reset
//   tick_os       oversample strobe, one clk wide, OVS per bit period
//   tx_data       word to send, LSB first
//   tx_start      a word is available (FIFO not empty)
//   cfg_parity    00/11 none, 01 even, 10 odd
//   cfg_stop2     0 = one stop bit, 1 = two stop bits
//   tx_break      request a line break (line held low)
//   i_cts_n       active-low clear-to-send
//   tx_out        serial line, idle high
//   tx_busy       a frame or a break is in progress
//   tx_done_tick  one-clk pulse at the end of each data frame
// -----------------------------------------------------------------------------
module uart_tx_cfg #(
  parameter int DATA_W = 8,
  parameter int OVS    = 16,
  parameter int CTS_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_os,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_start,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  input  logic              tx_break,
  input  logic              i_cts_n,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done_tick
);

  localparam int CNT_W = $clog2(OVS);
  localparam int IDX_W = $clog2(DATA_W);

  // The last tick of each bit and the index of the last data bit.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   tick_cnt;     // ticks spent in the current bit
  logic [IDX_W-1:0]   bit_idx;      // data bit currently on the line
  logic [DATA_W-1:0]  shift_reg;    // remaining data bits, next bit at [0]
  logic               par_en;       // parity mode latched at frame start
  logic               par_bit;      // parity value, computed once at frame start
  logic               stop2;        // stop-bit count latched at frame start
  logic               stop_second;  // set while the second stop bit is sent

  logic cts_clear;
  logic bit_last;

  // With CTS_EN=0 the peer is always treated as ready.
  assign cts_clear = (CTS_EN == 0) || !i_cts_n;

  // Last tick of the bit on the line; the next tick starts a new bit.
  assign bit_last = (tick_cnt == CNT_LAST);

  // NOTE: all state and outputs update with non-blocking assignments in a
  // single clocked process, so every branch reads the values from before the
  // edge and the outputs are glitch-free registers.
  // NOTE: the shift register and the other datapath registers are cleared by
  // reset as well, so a frame aborted by reset leaves no stale data behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_idx      <= '0;
      shift_reg    <= '0;
      par_en       <= 1'b0;
      par_bit      <= 1'b0;
      stop2        <= 1'b0;
      stop_second  <= 1'b0;
      tx_out       <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;

      if (tick_os) begin
        unique case (state)
          // ------------------------------------------------------------------
          IDLE: begin
            if (tx_break) begin
              // A break takes priority over a pending word.
              tx_out  <= 1'b0;
              tx_busy <= 1'b1;
              state   <= BREAK;
            end else if (tx_start && cts_clear) begin
              // Latch the word and its settings. Later changes to these
              // inputs do not affect the frame in flight.
              shift_reg   <= tx_data;
              par_en      <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
              par_bit     <= (^tx_data) ^ (cfg_parity == 2'b10);
              stop2       <= cfg_stop2;
              stop_second <= 1'b0;
              tick_cnt    <= '0;
              bit_idx     <= '0;
              // The start bit goes out on this edge, so the start bit has
              // already used one of its OVS ticks.
              tx_out      <= 1'b0;
              tx_busy     <= 1'b1;
              state       <= START;
            end else begin
              tx_out  <= 1'b1;
              tx_busy <= 1'b0;
            end
          end

          // ------------------------------------------------------------------
          START: begin
            if (bit_last) begin
              tick_cnt  <= '0;
              bit_idx   <= '0;
              tx_out    <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              state     <= DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          // ------------------------------------------------------------------
          DATA: begin
            if (bit_last) begin
              tick_cnt <= '0;
              if (bit_idx == IDX_LAST) begin
                if (par_en) begin
                  tx_out <= par_bit;
                  state  <= PARITY;
                end else begin
                  tx_out <= 1'b1;
                  state  <= STOP;
                end
              end else begin
                tx_out    <= shift_reg[0];
                shift_reg <= shift_reg >> 1;
                bit_idx   <= bit_idx + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          // ------------------------------------------------------------------
          PARITY: begin
            if (bit_last) begin
              tick_cnt <= '0;
              tx_out   <= 1'b1;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          // ------------------------------------------------------------------
          STOP: begin
            if (bit_last) begin
              tick_cnt <= '0;
              if (stop2 && !stop_second) begin
                // The line stays high; count a second full bit period.
                stop_second <= 1'b1;
              end else begin
                // End of frame. IDLE looks at tx_start again on the next
                // tick, which gives the FIFO pop one tick to settle.
                tx_busy      <= 1'b0;
                tx_done_tick <= 1'b1;
                state        <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          // ------------------------------------------------------------------
          BREAK: begin
            if (!tx_break) begin
              tx_out  <= 1'b1;
              tx_busy <= 1'b0;
              state   <= IDLE;
            end
          end

          default: begin
            tx_out  <= 1'b1;
            tx_busy <= 1'b0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
